uart_tx_arbiter: RTL

//  Shares the single UART transmitter (8-bit parallel in, valid/ready) between NUM_REQ byte sources.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, uart_tx_arbiter and the UART TX input port.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned GW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_input_data;
   logic                 tx_input_data_valid;
   logic                 tx_output_ready;
   logic [GW-1:0]        grant_id;
   logic                 busy;
   logic                 timeout_err;

   modport master (
      input  req_valid, req_data, req_last, tx_output_ready,
      output req_ready, tx_input_data, tx_input_data_valid, grant_id, busy, timeout_err
   );

   modport slave (
      output req_valid, req_data, req_last, tx_output_ready,
      input  req_ready, tx_input_data, tx_input_data_valid, grant_id, busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-based sharing of one UART transmitter among NUM_REQ byte sources.
// Optional SEND/DRAIN watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned MAX_BURST   = 16,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input logic               clk,
   input logic               enable,
   uart_tx_arbiter_if.master bus
);
   localparam int unsigned GW = $clog2(NUM_REQ);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StSend, StDrain} state_e;

   state_e              state_q, state_d;
   logic                rdy_meta_q, rdy_s_q;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       last_grant_q, last_grant_d;
   logic [CW-1:0]       burst_cnt_q, burst_cnt_d;
   logic [CW-1:0]       cnt_inc;
   logic [7:0]          data_q, data_d;
   logic                last_q, last_d;
   logic                valid_q, valid_d;
   logic [NUM_REQ-1:0]  req_ready;
   logic [GW-1:0]       pick;
   logic                found;
   int unsigned         idx;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tout_q, tout_d;
`endif

   // Rotating priority: first valid requester after the last one served.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(last_grant_q) + 32'd1 + k) % NUM_REQ;
         if (!found && bus.req_valid[GW'(idx)]) begin
            found = 1'b1;
            pick  = GW'(idx);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      burst_cnt_d  = burst_cnt_q;
      data_d       = data_q;
      last_d       = last_q;
      valid_d      = valid_q;
      req_ready    = '0;
      cnt_inc      = burst_cnt_q + CW'(1);
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d     = pick;
               burst_cnt_d = '0;
               state_d     = StLoad;
            end
         end
         StLoad: begin
            if (!bus.req_valid[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = StIdle;
            end else if (rdy_s_q) begin
               data_d             = bus.req_data[{grant_q, 3'b000} +: 8];
               last_d             = bus.req_last[grant_q];
               valid_d            = 1'b1;
               req_ready[grant_q] = 1'b1;
               state_d            = StSend;
            end
         end
         StSend: begin
            // Transmitter dropping ready means it has taken the byte.
            if (!rdy_s_q) begin
               valid_d = 1'b0;
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (rdy_s_q) begin
               burst_cnt_d = cnt_inc;
               if (last_q || (cnt_inc == CW'(MAX_BURST)) || !bus.req_valid[grant_q]) begin
                  last_grant_d = grant_q;
                  state_d      = StIdle;
               end else begin
                  state_d = StLoad;
               end
            end
         end
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      tout_d    = 1'b0;
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == StLoad && state_d == StSend) begin
         tmo_cnt_d = '0;
      end else if (state_q == StSend || state_q == StDrain) begin
         if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            valid_d      = 1'b0;
            tout_d       = 1'b1;
            last_grant_d = grant_q;
            state_d      = StIdle;
         end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!enable) begin
         state_q      <= StIdle;
         rdy_meta_q   <= 1'b0;
         rdy_s_q      <= 1'b0;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_REQ - 1);
         burst_cnt_q  <= '0;
         data_q       <= '0;
         last_q       <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rdy_meta_q   <= bus.tx_output_ready;
         rdy_s_q      <= rdy_meta_q;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         burst_cnt_q  <= burst_cnt_d;
         data_q       <= data_d;
         last_q       <= last_d;
         valid_q      <= valid_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!enable) begin
         tmo_cnt_q <= '0;
         tout_q    <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tout_q    <= tout_d;
      end
   end

   assign bus.timeout_err = tout_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.req_ready           = req_ready;
   assign bus.tx_input_data       = data_q;
   assign bus.tx_input_data_valid = valid_q;
   assign bus.grant_id            = grant_q;
   assign bus.busy                = (state_q != StIdle);
endmodule
